// File: rtl/alu_entry_ctrl_if.sv
// Keypad/display bundle between the calculator entry controller and its
// neighbours: raw pushbuttons in, display word and ALU status out.
interface alu_entry_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [20:0]          pb;
    logic [2*WIDTH-1:0]   disp_value;
    logic [WIDTH/2-1:0]   disp_blank;
    logic [WIDTH-1:0]     result;
    logic [2:0]           flags;
    logic [2:0]           op;
    logic [1:0]           state;
    logic                 result_valid;

    // Board side: drives the buttons, observes the display and status.
    modport master (
        output pb,
        input  disp_value, disp_blank, result, flags, op, state, result_valid
    );

    // Controller side.
    modport slave (
        input  pb,
        output disp_value, disp_blank, result, flags, op, state, result_valid
    );
endinterface

// File: rtl/alu_entry_ctrl.sv
// Calculator keypad front end: synchronises and edge-detects pushbuttons,
// sequences operand/opcode entry, computes the ALU result and drives a
// registered display word with per-digit blanking for the 7-seg mux.
module alu_entry_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          hz100,
    input  logic          reset,
    alu_entry_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ENTER_A   = 2'd0,
        ENTER_B   = 2'd1,
        SELECT_OP = 2'd2,
        SHOW      = 3'd3
    } state_t;

    localparam int ND = WIDTH / 4;  // hex digits per operand

    logic [SYNC_STAGES-1:0][19:0] sync_q;
    logic [19:0]                  edge_q;
    logic [19:0]                  evt;

    state_t             st, st_n;
    logic [WIDTH-1:0]   opa, opa_n, opb, opb_n;
    logic [2:0]         op_q, op_n;
    logic [WIDTH-1:0]   res_q, res_n;
    logic [2:0]         flags_q, flags_n;
    logic               rv_q, rv_n;
    logic               chg, chg_q;

    logic               is_abort, is_clear, is_enter, is_opnext, is_hex;
    logic [3:0]         key;
    logic               found;

    logic [WIDTH:0]     a1, b1, wide, shr_t;
    logic [2:0]         sh;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;

    logic [2*WIDTH-1:0] dval_q, dval_n;
    logic [2*ND-1:0]    dblk_q, dblk_n;

    // Button synchroniser chain followed by the previous-value edge register.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            edge_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pb[19:0]};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign evt = sync_q[SYNC_STAGES-1] & ~edge_q;

    // Priority arbitration: one event per cycle, lowest hex key wins.
    always_comb begin
        is_abort  = evt[19];
        is_clear  = !evt[19] && evt[17];
        is_enter  = !evt[19] && !evt[17] && evt[16];
        is_opnext = !evt[19] && !evt[17] && !evt[16] && evt[18];
        is_hex    = !evt[19] && !evt[17] && !evt[16] && !evt[18] && (|evt[15:0]);
        key   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (evt[i] && !found) begin
                key   = 4'(i);
                found = 1'b1;
            end
        end
    end

    // ALU in WIDTH+1 bits; the extra bit carries C for add/sub/shift-left,
    // and shift-right keeps the last bit out below the LSB.
    always_comb begin
        a1    = {1'b0, opa};
        b1    = {1'b0, opb};
        sh    = opb[2:0];
        wide  = '0;
        shr_t = '0;
        alu_c = 1'b0;
        case (op_q)
            3'd0: begin wide = a1 + b1; alu_c = wide[WIDTH]; end
            3'd1: begin wide = a1 - b1; alu_c = wide[WIDTH]; end
            3'd2: wide = a1 & b1;
            3'd3: wide = a1 | b1;
            3'd4: wide = a1 ^ b1;
            3'd5: begin wide = a1 << sh; alu_c = wide[WIDTH]; end
            3'd6: begin
                shr_t = {opa, 1'b0} >> sh;
                wide  = {1'b0, shr_t[WIDTH:1]};
                alu_c = shr_t[0];
            end
            default: wide = {1'b0, ~opa};
        endcase
        alu_res = wide[WIDTH-1:0];
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            st      <= ENTER_A;
            opa     <= '0;
            opb     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flags_q <= '0;
            rv_q    <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            st      <= st_n;
            opa     <= opa_n;
            opb     <= opb_n;
            op_q    <= op_n;
            res_q   <= res_n;
            flags_q <= flags_n;
            rv_q    <= rv_n;
            chg_q   <= chg;
        end
    end

    // Next-state and operand update for the arbitrated event.
    always_comb begin
        st_n    = st;
        opa_n   = opa;
        opb_n   = opb;
        op_n    = op_q;
        res_n   = res_q;
        flags_n = flags_q;
        rv_n    = 1'b0;
        case (st)
            ENTER_A: begin
                if (is_hex)        opa_n = (opa << 4) | WIDTH'(key);
                else if (is_clear) opa_n = '0;
                else if (is_enter) begin
                    st_n  = ENTER_B;
                    opb_n = '0;
                end
            end
            ENTER_B: begin
                if (is_hex)        opb_n = (opb << 4) | WIDTH'(key);
                else if (is_clear) opb_n = '0;
                else if (is_enter) st_n = SELECT_OP;
            end
            SELECT_OP: begin
                if (is_opnext) op_n = op_q + 3'd1;
                else if (is_enter) begin
                    res_n   = alu_res;
                    flags_n = {alu_res[WIDTH-1], alu_c, (alu_res == '0)};
                    rv_n    = 1'b1;
                    st_n    = SHOW;
                end
            end
            default: begin
                if (is_hex) begin
                    opa_n = WIDTH'(key);
                    st_n  = ENTER_A;
                end else if (is_enter) begin
                    opa_n = res_q;
                    opb_n = '0;
                    st_n  = ENTER_B;
                end
            end
        endcase
        if (is_abort) begin
            st_n  = ENTER_A;
            opa_n = '0;
            opb_n = '0;
            op_n  = '0;
        end
        chg = (st_n != st) || (opa_n != opa) || (opb_n != opb) ||
              (op_n != op_q) || rv_n;
    end

    // Display word and blanking derived from the settled registers.
    always_comb begin
        dval_n = '0;
        dblk_n = '0;
        case (st)
            ENTER_A: begin
                dval_n = {{WIDTH{1'b0}}, opa};
                for (int unsigned i = ND; i < 2*ND; i++) dblk_n[i] = 1'b1;
            end
            ENTER_B: dval_n = {opa, opb};
            SELECT_OP: begin
                dval_n = {WIDTH'(op_q), opb};
                for (int unsigned i = ND + 1; i < 2*ND; i++) dblk_n[i] = 1'b1;
            end
            default: begin
                dval_n = {{WIDTH{1'b0}}, res_q};
                for (int unsigned i = ND; i < 2*ND; i++) dblk_n[i] = 1'b1;
            end
        endcase
    end

    // Display refreshes only the cycle after a visible change, so the
    // all-blank reset pattern holds until the first accepted event.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            dval_q <= '0;
            dblk_q <= '1;
        end else if (chg_q) begin
            dval_q <= dval_n;
            dblk_q <= dblk_n;
        end
    end

    assign bus.disp_value   = dval_q;
    assign bus.disp_blank   = dblk_q;
    assign bus.result       = res_q;
    assign bus.flags        = flags_q;
    assign bus.op           = op_q;
    assign bus.state        = st;
    assign bus.result_valid = rv_q;

endmodule

// File: tb/tb_alu_entry_ctrl.sv
// Self-checking bench for alu_entry_ctrl: directed keypad sequences plus
// random presses, compared against a behavioural calculator model.
module tb_alu_entry_ctrl;

    localparam int W = 8;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_entry_ctrl_if #(.WIDTH(W)) bus ();

    alu_entry_ctrl #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .hz100 (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int rv_seen = 0;

    // Model state: state, operands, opcode, last result and flags.
    int m_st, m_a, m_b, m_op, m_res, m_flags, m_rv, m_dv, m_db;

    always @(negedge clk) if (rst_n && bus.result_valid === 1'b1) rv_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 0;
        m_dv = 0; m_db = 'hF;
    endtask

    task automatic model_alu(output int r, output int c);
        int sh;
        sh = m_b % 8;
        c = 0;
        case (m_op)
            0: begin r = (m_a + m_b) % 256; c = (m_a + m_b > 255); end
            1: begin r = (m_a - m_b + 256) % 256; c = (m_a < m_b); end
            2: r = m_a & m_b;
            3: r = m_a | m_b;
            4: r = m_a ^ m_b;
            5: begin r = (m_a << sh) % 256; c = (sh == 0) ? 0 : (m_a >> (8 - sh)) % 2; end
            6: begin r = m_a >> sh; c = (sh == 0) ? 0 : (m_a >> (sh - 1)) % 2; end
            default: r = 255 - m_a;
        endcase
    endtask

    task automatic model_event(input logic [20:0] mask);
        int key, o_st, o_a, o_b, o_op, r, c;
        bit pulse;
        key = -1;
        for (int k = 15; k >= 0; k--) if (mask[k]) key = k;
        o_st = m_st; o_a = m_a; o_b = m_b; o_op = m_op;
        pulse = 0;
        if (mask[19]) begin
            m_st = 0; m_a = 0; m_b = 0; m_op = 0;
        end else if (mask[17]) begin
            if (m_st == 0) m_a = 0;
            else if (m_st == 1) m_b = 0;
        end else if (mask[16]) begin
            case (m_st)
                0: begin m_st = 1; m_b = 0; end
                1: m_st = 2;
                2: begin
                    model_alu(r, c);
                    m_res = r;
                    m_flags = (r / 128) * 4 + c * 2 + ((r == 0) ? 1 : 0);
                    m_rv++; pulse = 1; m_st = 3;
                end
                default: begin m_a = m_res; m_b = 0; m_st = 1; end
            endcase
        end else if (mask[18]) begin
            if (m_st == 2) m_op = (m_op + 1) % 8;
        end else if (key >= 0) begin
            case (m_st)
                0: m_a = (m_a * 16 + key) % 256;
                1: m_b = (m_b * 16 + key) % 256;
                3: begin m_a = key; m_st = 0; end
                default: ;
            endcase
        end
        if (pulse || o_st != m_st || o_a != m_a || o_b != m_b || o_op != m_op) begin
            case (m_st)
                0: begin m_dv = m_a;             m_db = 'hC; end
                1: begin m_dv = m_a * 256 + m_b; m_db = 0;   end
                2: begin m_dv = m_op * 256 + m_b; m_db = 'h8; end
                default: begin m_dv = m_res;     m_db = 'hC; end
            endcase
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".state"}, 32'(bus.state), 32'(m_st));
        check({tag, ".op"}, 32'(bus.op), 32'(m_op));
        check({tag, ".result"}, 32'(bus.result), 32'(m_res));
        check({tag, ".flags"}, 32'(bus.flags), 32'(m_flags));
        check({tag, ".disp_value"}, 32'(bus.disp_value), 32'(m_dv));
        check({tag, ".disp_blank"}, 32'(bus.disp_blank), 32'(m_db));
        check({tag, ".rv_count"}, 32'(rv_seen), 32'(m_rv));
    endtask

    // Press a button set, hold it, release, and let the pipeline settle.
    task automatic press(input logic [20:0] mask, input bit timed);
        int o_st, hold;
        @(negedge clk);
        o_st = m_st;
        bus.pb = mask;
        model_event(mask);
        if (timed) begin
            repeat (S) @(posedge clk);
            #1 check("evt_not_early", 32'(bus.state), 32'(o_st));
            @(posedge clk);
            #1 check("evt_latency", 32'(bus.state), 32'(m_st));
            @(negedge clk);
        end else begin
            hold = $urandom_range(1, 4);
            repeat (hold) @(negedge clk);
        end
        bus.pb = '0;
        repeat (S + 4) @(negedge clk);
        compare_all("press");
    endtask

    task automatic hex(input int k);
        press(21'(1) << k, 1'b0);
    endtask

    localparam logic [20:0] ENT = 21'(1) << 16;
    localparam logic [20:0] CLR = 21'(1) << 17;
    localparam logic [20:0] OPN = 21'(1) << 18;
    localparam logic [20:0] ABT = 21'(1) << 19;

    initial begin
        logic [20:0] m;
        int r;
        bus.pb = '0;
        m_rv = 0;
        model_reset();

        // Reset held three cycles.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.state", 32'(bus.state), 0);
        check("rst.disp_value", 32'(bus.disp_value), 0);
        check("rst.disp_blank", 32'(bus.disp_blank), 'hF);
        check("rst.result", 32'(bus.result), 0);
        check("rst.rv", 32'(bus.result_valid), 0);

        // 0x37 + 0x29.
        hex(3); hex(7); press(ENT, 1'b1);
        hex(2); hex(9); press(ENT, 1'b0); press(ENT, 1'b0);
        check("add.result", 32'(bus.result), 'h60);
        check("add.flags", 32'(bus.flags), 0);
        check("add.disp", 32'(bus.disp_value), 'h0060);
        check("add.pulses", 32'(rv_seen), 1);

        // 5 - 7 then chain.
        press(ABT, 1'b0);
        hex(0); hex(5); press(ENT, 1'b0); hex(0); hex(7); press(ENT, 1'b0);
        press(OPN, 1'b0); press(ENT, 1'b0);
        check("sub.result", 32'(bus.result), 'hFE);
        check("sub.flags", 32'(bus.flags), 'b110);
        press(ENT, 1'b0);
        check("chain.state", 32'(bus.state), 1);
        check("chain.disp", 32'(bus.disp_value), 'hFE00);

        // Wrap-around entry and arbitration.
        press(ABT, 1'b0);
        hex(1); hex(2); hex(3);
        check("wrap.disp", 32'(bus.disp_value), 'h0023);
        press((21'(1) << 4) | (21'(1) << 9), 1'b0);
        check("lowkey.disp", 32'(bus.disp_value), 'h0034);
        press(ENT | OPN, 1'b0);
        check("ent_over_opn.state", 32'(bus.state), 1);
        check("ent_over_opn.op", 32'(bus.op), 0);

        // Opcode wrap, SHL, NOT.
        press(ENT, 1'b0);
        repeat (8) press(OPN, 1'b0);
        check("opwrap", 32'(bus.op), 0);
        press(ABT, 1'b0);
        hex(8); hex(1); press(ENT, 1'b0); hex(1); press(ENT, 1'b0);
        repeat (5) press(OPN, 1'b0);
        press(ENT, 1'b0);
        check("shl.result", 32'(bus.result), 'h02);
        check("shl.flags", 32'(bus.flags), 'b010);
        press(ABT, 1'b0);
        hex(15); hex(15); press(ENT, 1'b0); press(ENT, 1'b0);
        repeat (7) press(OPN, 1'b0);
        press(ENT, 1'b0);
        check("not.result", 32'(bus.result), 0);
        check("not.flags", 32'(bus.flags), 'b001);

        // Reset in SELECT_OP.
        press(ABT, 1'b0);
        hex(1); press(ENT, 1'b0); hex(2); press(ENT, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.state", 32'(bus.state), 0);
        check("midrst.result", 32'(bus.result), 0);
        check("midrst.blank", 32'(bus.disp_blank), 'hF);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("after_midrst");

        // ABORT in ENTER_B.
        hex(5); press(ENT, 1'b0); hex(6);
        press(ABT, 1'b0);
        check("abort.state", 32'(bus.state), 0);
        check("abort.disp", 32'(bus.disp_value), 0);

        // Random presses against the model.
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      m = 21'(1) << $urandom_range(0, 15);
            else if (r < 65) m = ENT;
            else if (r < 78) m = OPN;
            else if (r < 85) m = CLR;
            else if (r < 90) m = ABT;
            else if (r < 95) m = (21'(1) << $urandom_range(0, 20)) | (21'(1) << $urandom_range(0, 20));
            else             m = 21'(1) << 20;
            press(m, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
